// File: rtl/wbl_row_writer.sv
// Row loader: pulls one row of WBL words from the upstream key generator and
// writes it word by word into the array, for every row in turn.
module wbl_row_writer #(
  parameter int ROWS  = 64,
  parameter int BANKS = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic                  KEY_DONE,
  input  logic [BANKS*64-1:0]   WBL_IN,
  output logic [5:0]            ADDR,
  output logic                  WR_EN,
  output logic [5:0]            WR_ROW,
  output logic [3:0]            WR_BANK,
  output logic [63:0]           WR_DATA,
  input  logic                  WR_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam logic [5:0] ROW_LAST  = 6'(ROWS - 1);
  localparam logic [3:0] BANK_LAST = 4'(BANKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETADDR,
    S_CAPTURE,
    S_WRITE,
    S_FIN
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  row_reg, row_next;
  logic [3:0]  bank_reg, bank_next;
  logic [5:0]  addr_reg, addr_next;
  logic        err_reg, err_next;
  logic        capture;
  logic [63:0] buf_word [BANKS];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= S_IDLE;
      row_reg   <= '0;
      bank_reg  <= '0;
      addr_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      bank_reg  <= bank_next;
      addr_reg  <= addr_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    bank_next  = bank_reg;
    addr_next  = addr_reg;
    err_next   = 1'b0;
    capture    = 1'b0;

    unique case (state_reg)
      S_IDLE, S_FIN: begin
        if (START) begin
          if (KEY_DONE) begin
            state_next = S_SETADDR;
            row_next   = '0;
            bank_next  = '0;
            addr_next  = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      default: begin
        // ABORT outranks a lost KEY_DONE: a cancelled load never flags an error.
        if (ABORT) begin
          state_next = S_IDLE;
        end else if (!KEY_DONE) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end else begin
          unique case (state_reg)
            S_SETADDR: state_next = S_CAPTURE;
            S_CAPTURE: begin
              capture    = 1'b1;
              bank_next  = '0;
              state_next = S_WRITE;
            end
            S_WRITE: begin
              if (WR_READY) begin
                if (bank_reg != BANK_LAST) begin
                  bank_next = bank_reg + 4'd1;
                end else if (row_reg != ROW_LAST) begin
                  row_next   = row_reg + 6'd1;
                  addr_next  = row_reg + 6'd1;
                  state_next = S_SETADDR;
                end else begin
                  state_next = S_FIN;
                end
              end
            end
            default: state_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // One 64-bit register per bank; the whole row is latched in a single edge.
  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_buf
      logic [63:0] word_reg;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          word_reg <= '0;
        end else if (capture) begin
          word_reg <= WBL_IN[gi*64 +: 64];
        end
      end
      assign buf_word[gi] = word_reg;
    end
  endgenerate

  assign ADDR    = addr_reg;
  assign WR_EN   = (state_reg == S_WRITE);
  assign WR_ROW  = row_reg;
  assign WR_BANK = bank_reg;
  assign WR_DATA = buf_word[bank_reg];
  assign BUSY    = (state_reg == S_SETADDR) || (state_reg == S_CAPTURE) ||
                   (state_reg == S_WRITE);
  assign DONE    = (state_reg == S_FIN);
  assign ERR     = err_reg;

endmodule
